// File: rtl/id_stall_controller_pkg.sv
// Shared pipeline definitions for the ID-stage interlock: FSM encoding and
// register-index constants.
package id_stall_controller_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] X0 = 5'd0;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_match.sv
// One producer-versus-ID-operand comparison: high when the qualified producer
// writes a non-x0 register that the ID instruction actually reads.
module hazard_match
    import id_stall_controller_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 rd_qual,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic                 uses_rs1,
    input  logic                 uses_rs2,
    output logic                 hit
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // Compare the producer destination against each operand the ID instruction reads.
    always_comb begin
        rs1_hit_s = uses_rs1 && (rd == rs1);
        rs2_hit_s = uses_rs2 && (rd == rs2);
        hit       = rd_qual && (rd != X0) && (rs1_hit_s || rs2_hit_s);
    end

endmodule

// File: rtl/id_stall_controller.sv
// Pipeline interlock: stalls the front end on unresolvable ID hazards, freezes
// the pipeline on data-memory busy, flushes IF_ID on taken branches.
module id_stall_controller
    import id_stall_controller_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] ID_rs1,
    input  logic [REG_IDX_W-1:0] ID_rs2,
    input  logic                 ID_uses_rs1,
    input  logic                 ID_uses_rs2,
    input  logic                 ID_is_branch,
    input  logic                 ID_branch_taken,
    input  logic [REG_IDX_W-1:0] ID_EX_rd,
    input  logic                 ID_EX_regwrite,
    input  logic                 ID_EX_memread,
    input  logic [REG_IDX_W-1:0] EX_MEM_rd,
    input  logic                 EX_MEM_regwrite,
    input  logic                 EX_MEM_memread,
    input  logic                 dmem_busy,
    output logic                 PC_write_enable,
    output logic                 IF_ID_write_enable,
    output logic                 IF_ID_flush,
    output logic                 ID_EX_write_enable,
    output logic                 ID_EX_bubble,
    output logic                 EX_MEM_write_enable,
    output logic                 MEM_WB_bubble,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] dmem_wait_cycles,
    output logic                 dmem_timeout
);

    localparam int RL_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(MEM_TIMEOUT);

    logic load_use_s;
    logic br_ex_s;
    logic br_mem_s;
    logic hazard_s;

    state_e               state_q, state_d;
    logic [RL_W-1:0]      run_len_q, run_len_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_WIDTH-1:0] dmem_wait_cycles_q, dmem_wait_cycles_d;
    logic                 dmem_timeout_q, dmem_timeout_d;

    hazard_match u_load_use (
        .rd       (ID_EX_rd),
        .rd_qual  (ID_EX_memread && ID_EX_regwrite),
        .rs1      (ID_rs1),
        .rs2      (ID_rs2),
        .uses_rs1 (ID_uses_rs1),
        .uses_rs2 (ID_uses_rs2),
        .hit      (load_use_s)
    );

    hazard_match u_branch_ex (
        .rd       (ID_EX_rd),
        .rd_qual  (ID_is_branch && ID_EX_regwrite),
        .rs1      (ID_rs1),
        .rs2      (ID_rs2),
        .uses_rs1 (ID_uses_rs1),
        .uses_rs2 (ID_uses_rs2),
        .hit      (br_ex_s)
    );

    hazard_match u_branch_mem (
        .rd       (EX_MEM_rd),
        .rd_qual  (ID_is_branch && EX_MEM_memread && EX_MEM_regwrite),
        .rs1      (ID_rs1),
        .rs2      (ID_rs2),
        .uses_rs1 (ID_uses_rs1),
        .uses_rs2 (ID_uses_rs2),
        .hit      (br_mem_s)
    );

    assign hazard_s = load_use_s || br_ex_s || br_mem_s;

    // Pipeline control: freeze and stall are combinational so they act in the same cycle.
    always_comb begin
        PC_write_enable     = 1'b1;
        IF_ID_write_enable  = 1'b1;
        IF_ID_flush         = 1'b0;
        ID_EX_write_enable  = 1'b1;
        ID_EX_bubble        = 1'b0;
        EX_MEM_write_enable = 1'b1;
        MEM_WB_bubble       = 1'b0;
        if (rst) begin
            PC_write_enable     = 1'b0;
            IF_ID_write_enable  = 1'b0;
            IF_ID_flush         = 1'b1;
            ID_EX_write_enable  = 1'b0;
            ID_EX_bubble        = 1'b1;
            EX_MEM_write_enable = 1'b0;
            MEM_WB_bubble       = 1'b1;
        end else if (dmem_busy) begin
            PC_write_enable     = 1'b0;
            IF_ID_write_enable  = 1'b0;
            ID_EX_write_enable  = 1'b0;
            EX_MEM_write_enable = 1'b0;
            MEM_WB_bubble       = 1'b1;
        end else if (hazard_s) begin
            // Branch operands are stale here, so a taken indication must not flush.
            PC_write_enable    = 1'b0;
            IF_ID_write_enable = 1'b0;
            ID_EX_bubble       = 1'b1;
        end else if (ID_branch_taken) begin
            IF_ID_flush = 1'b1;
        end else begin
            IF_ID_flush = 1'b0;
        end
    end

    // Next-state for the wait FSM, busy run length, counters and sticky timeout.
    always_comb begin
        state_d            = state_q;
        run_len_d          = run_len_q;
        stall_cycles_d     = stall_cycles_q;
        dmem_wait_cycles_d = dmem_wait_cycles_q;
        dmem_timeout_d     = dmem_timeout_q;

        case (state_q)
            ST_RUN:      state_d = dmem_busy ? ST_MEM_WAIT : ST_RUN;
            ST_MEM_WAIT: state_d = dmem_busy ? ST_MEM_WAIT : ST_RUN;
            default:     state_d = ST_RUN;
        endcase

        // A busy cycle seen from RUN starts a new run; MEM_WAIT extends it.
        if (!dmem_busy) begin
            run_len_d = '0;
        end else if (state_q == ST_RUN) begin
            run_len_d = RL_W'(1);
        end else if (run_len_q != RL_MAX) begin
            run_len_d = run_len_q + RL_W'(1);
        end else begin
            run_len_d = run_len_q;
        end

        if (dmem_busy && (run_len_d == RL_MAX)) begin
            dmem_timeout_d = 1'b1;
        end else begin
            dmem_timeout_d = dmem_timeout_q;
        end

        if (dmem_busy && (dmem_wait_cycles_q != {CNT_WIDTH{1'b1}})) begin
            dmem_wait_cycles_d = dmem_wait_cycles_q + CNT_WIDTH'(1);
        end else begin
            dmem_wait_cycles_d = dmem_wait_cycles_q;
        end

        if (!dmem_busy && hazard_s && (stall_cycles_q != {CNT_WIDTH{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_RUN;
            run_len_q          <= '0;
            stall_cycles_q     <= '0;
            dmem_wait_cycles_q <= '0;
            dmem_timeout_q     <= 1'b0;
        end else begin
            state_q            <= state_d;
            run_len_q          <= run_len_d;
            stall_cycles_q     <= stall_cycles_d;
            dmem_wait_cycles_q <= dmem_wait_cycles_d;
            dmem_timeout_q     <= dmem_timeout_d;
        end
    end

    assign stall_cycles     = stall_cycles_q;
    assign dmem_wait_cycles = dmem_wait_cycles_q;
    assign dmem_timeout     = dmem_timeout_q;

endmodule

// File: tb/tb_id_stall_controller.sv
// Directed bench for id_stall_controller with MEM_TIMEOUT=4: each step drives
// inputs after a falling edge, checks control outputs, then counters after the edge.
module tb_id_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs1, ID_rs2, ID_EX_rd, EX_MEM_rd;
    logic        ID_uses_rs1, ID_uses_rs2, ID_is_branch, ID_branch_taken;
    logic        ID_EX_regwrite, ID_EX_memread, EX_MEM_regwrite, EX_MEM_memread;
    logic        dmem_busy;
    logic        PC_write_enable, IF_ID_write_enable, IF_ID_flush;
    logic        ID_EX_write_enable, ID_EX_bubble, EX_MEM_write_enable, MEM_WB_bubble;
    logic [31:0] stall_cycles, dmem_wait_cycles;
    logic        dmem_timeout;
    logic [6:0]  outs;

    int n_cmp = 0;
    int n_err = 0;

    // {PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_bubble, EX_MEM_we, MEM_WB_bubble}
    localparam logic [6:0] O_RST    = 7'b0010101;
    localparam logic [6:0] O_FREEZE = 7'b0000001;
    localparam logic [6:0] O_STALL  = 7'b0001110;
    localparam logic [6:0] O_TAKEN  = 7'b1111010;
    localparam logic [6:0] O_RUN    = 7'b1101010;

    always #5 clk = ~clk;

    assign outs = {PC_write_enable, IF_ID_write_enable, IF_ID_flush, ID_EX_write_enable,
                   ID_EX_bubble, EX_MEM_write_enable, MEM_WB_bubble};

    id_stall_controller #(.CNT_WIDTH(32), .MEM_TIMEOUT(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ID_rs1              (ID_rs1),
        .ID_rs2              (ID_rs2),
        .ID_uses_rs1         (ID_uses_rs1),
        .ID_uses_rs2         (ID_uses_rs2),
        .ID_is_branch        (ID_is_branch),
        .ID_branch_taken     (ID_branch_taken),
        .ID_EX_rd            (ID_EX_rd),
        .ID_EX_regwrite      (ID_EX_regwrite),
        .ID_EX_memread       (ID_EX_memread),
        .EX_MEM_rd           (EX_MEM_rd),
        .EX_MEM_regwrite     (EX_MEM_regwrite),
        .EX_MEM_memread      (EX_MEM_memread),
        .dmem_busy           (dmem_busy),
        .PC_write_enable     (PC_write_enable),
        .IF_ID_write_enable  (IF_ID_write_enable),
        .IF_ID_flush         (IF_ID_flush),
        .ID_EX_write_enable  (ID_EX_write_enable),
        .ID_EX_bubble        (ID_EX_bubble),
        .EX_MEM_write_enable (EX_MEM_write_enable),
        .MEM_WB_bubble       (MEM_WB_bubble),
        .stall_cycles        (stall_cycles),
        .dmem_wait_cycles    (dmem_wait_cycles),
        .dmem_timeout        (dmem_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
        ID_is_branch = 1'b0; ID_branch_taken = 1'b0;
        ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
        EX_MEM_rd = 5'd0; EX_MEM_regwrite = 1'b0; EX_MEM_memread = 1'b0;
        dmem_busy = 1'b0;
    endtask

    // Check combinational controls mid-cycle, then let one rising edge pass.
    task automatic step(input string tag, input logic [6:0] exp_o);
        #1;
        chk(tag, {25'd0, outs}, {25'd0, exp_o});
        @(negedge clk);
    endtask

    task automatic cnt(input string tag, input int exp_stall, input int exp_wait, input logic exp_to);
        chk({tag, "_stall"}, stall_cycles, exp_stall);
        chk({tag, "_wait"}, dmem_wait_cycles, exp_wait);
        chk({tag, "_to"}, {31'd0, dmem_timeout}, {31'd0, exp_to});
    endtask

    initial begin
        clr();
        rst = 1'b1;
        step("reset", O_RST);
        cnt("reset", 0, 0, 1'b0);
        rst = 1'b0;
        step("idle", O_RUN);

        // Load-use: load x5 in EX, ID reads x5 -> one stall, then flow.
        ID_EX_rd = 5'd5; ID_EX_regwrite = 1'b1; ID_EX_memread = 1'b1;
        ID_rs1 = 5'd5; ID_uses_rs1 = 1'b1;
        step("lu_stall", O_STALL);
        cnt("lu_stall", 1, 0, 1'b0);
        ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
        EX_MEM_rd = 5'd5; EX_MEM_regwrite = 1'b1; EX_MEM_memread = 1'b1;
        step("lu_flow", O_RUN);
        cnt("lu_flow", 1, 0, 1'b0);

        // Branch on load x7 with taken held: two stalls, then flush.
        clr();
        ID_EX_rd = 5'd7; ID_EX_regwrite = 1'b1; ID_EX_memread = 1'b1;
        ID_rs1 = 5'd7; ID_uses_rs1 = 1'b1; ID_is_branch = 1'b1; ID_branch_taken = 1'b1;
        step("bl_stall1", O_STALL);
        ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
        EX_MEM_rd = 5'd7; EX_MEM_regwrite = 1'b1; EX_MEM_memread = 1'b1;
        step("bl_stall2", O_STALL);
        cnt("bl_stall2", 3, 0, 1'b0);
        EX_MEM_rd = 5'd0; EX_MEM_regwrite = 1'b0; EX_MEM_memread = 1'b0;
        step("bl_taken", O_TAKEN);
        clr();
        step("bl_after", O_RUN);
        cnt("bl_after", 3, 0, 1'b0);

        // Branch on ALU result in EX via rs2; rs2 match without use is harmless.
        ID_EX_rd = 5'd9; ID_EX_regwrite = 1'b1;
        ID_rs2 = 5'd9; ID_uses_rs2 = 1'b1; ID_is_branch = 1'b1;
        step("balu_stall", O_STALL);
        ID_uses_rs2 = 1'b0;
        step("balu_nouse", O_RUN);
        cnt("balu", 4, 0, 1'b0);

        // x0 never hazards.
        clr();
        ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b1; ID_EX_memread = 1'b1;
        ID_rs1 = 5'd0; ID_uses_rs1 = 1'b1;
        step("x0", O_RUN);
        cnt("x0", 4, 0, 1'b0);

        // Freeze over a load-use hazard for 3 cycles, then the stall.
        clr();
        ID_EX_rd = 5'd5; ID_EX_regwrite = 1'b1; ID_EX_memread = 1'b1;
        ID_rs1 = 5'd5; ID_uses_rs1 = 1'b1; dmem_busy = 1'b1;
        step("frz1", O_FREEZE);
        ID_branch_taken = 1'b1;
        step("frz2", O_FREEZE);
        ID_branch_taken = 1'b0;
        step("frz3", O_FREEZE);
        cnt("frz3", 4, 3, 1'b0);
        dmem_busy = 1'b0;
        step("frz_stall", O_STALL);
        cnt("frz_stall", 5, 3, 1'b0);

        // Taken branch without hazard: single-cycle flush.
        clr();
        ID_is_branch = 1'b1; ID_branch_taken = 1'b1;
        step("taken", O_TAKEN);
        clr();
        step("taken_after", O_RUN);

        // Timeout: busy 5 cycles with MEM_TIMEOUT=4.
        dmem_busy = 1'b1;
        step("to_b1", O_FREEZE);
        step("to_b2", O_FREEZE);
        step("to_b3", O_FREEZE);
        cnt("to_b3", 5, 6, 1'b0);
        step("to_b4", O_FREEZE);
        cnt("to_b4", 5, 7, 1'b1);
        step("to_b5", O_FREEZE);
        dmem_busy = 1'b0;
        step("to_idle", O_RUN);
        cnt("to_idle", 5, 8, 1'b1);

        // Reset in the middle of a freeze discards everything.
        dmem_busy = 1'b1;
        step("pre_rst", O_FREEZE);
        rst = 1'b1;
        step("mid_rst", O_RST);
        cnt("mid_rst", 0, 0, 1'b0);
        rst = 1'b0; dmem_busy = 1'b0;
        ID_EX_rd = 5'd5; ID_EX_regwrite = 1'b1; ID_EX_memread = 1'b1;
        ID_rs1 = 5'd5; ID_uses_rs1 = 1'b1;
        step("post_rst", O_STALL);
        cnt("post_rst", 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
